// File: rtl/puf_resp_uart_tx.sv
// rtl/puf_resp_uart_tx.sv - 64-bit PUF/RNG response to ASCII hex line over 8N1 UART
`timescale 1ns/1ps
module puf_resp_uart_tx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int DATA_W   = 64
) (
    input  logic              CLK100MHZ,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] resp_data,
    input  logic              resp_valid,
    output logic              resp_ready,
    output logic              uart_tx,
    output logic              busy,
    output logic [15:0]       frames_sent
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [4:0]        byte_q, byte_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [7:0]        char_q, char_d;
    logic              tx_q, tx_d;
    logic [15:0]       frames_q, frames_d;

    logic              accept;
    logic              baud_done;
    logic [5:0]        shamt;
    logic [DATA_W-1:0] shifted;
    logic [3:0]        nib;
    logic [7:0]        line_char;
    logic [2:0]        bit_nx;

    // Ready is gated by reset_n so the source never sees ready while reset is held.
    assign resp_ready  = (state_q == S_IDLE) && reset_n;
    assign busy        = (state_q != S_IDLE);
    assign uart_tx     = tx_q;
    assign frames_sent = frames_q;
    assign accept      = resp_valid & resp_ready;
    assign baud_done   = (baud_q == BAUD_LAST);
    assign bit_nx      = bit_q + 3'd1;

    always_comb begin
        shamt     = 6'd60 - {byte_q[3:0], 2'b00};
        shifted   = shadow_q >> shamt;
        nib       = shifted[3:0];
        line_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        if (byte_q == 5'd16) line_char = 8'h0D;
        else if (byte_q == 5'd17) line_char = 8'h0A;
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + BAUD_ONE;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shadow_d = shadow_q;
        char_d   = char_q;
        tx_d     = tx_q;
        frames_d = frames_q;
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (accept) begin
                    shadow_d = resp_data;
                    byte_d   = 5'd0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                // tx is registered, so the start bit is launched on the LOAD exit edge.
                char_d  = line_char;
                baud_d  = '0;
                tx_d    = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = char_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_nx;
                        tx_d  = char_q[bit_nx];
                    end
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    tx_d   = 1'b1;
                    if (byte_q == 5'd17) begin
                        frames_d = frames_q + 16'd1;
                        state_d  = S_IDLE;
                    end else begin
                        byte_d  = byte_q + 5'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            byte_q   <= 5'd0;
            shadow_q <= '0;
            char_q   <= 8'h00;
            tx_q     <= 1'b1;
            frames_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shadow_q <= shadow_d;
            char_q   <= char_d;
            tx_q     <= tx_d;
            frames_q <= frames_d;
        end
    end
endmodule

// File: tb/tb_puf_resp_uart_tx.sv
// tb/tb_puf_resp_uart_tx.sv - directed line checks for puf_resp_uart_tx at 10 clocks per bit
`timescale 1ns/1ps
module tb_puf_resp_uart_tx;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] resp_data;
    logic        resp_valid;
    logic        resp_ready;
    logic        uart_tx;
    logic        busy;
    logic [15:0] frames_sent;

    int n_vec = 0;
    int n_bad = 0;
    int exp_frames = 0;

    always #5 clk = ~clk;

    puf_resp_uart_tx #(.CLK_FREQ(1000), .BAUD(100), .DATA_W(64)) dut (
        .CLK100MHZ   (clk),
        .reset_n     (reset_n),
        .resp_data   (resp_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rx_byte(output logic [7:0] b);
        int n = 0;
        b = 8'h00;
        while (uart_tx !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (uart_tx !== 1'b0) begin
            chk("rx_start_timeout", {63'b0, uart_tx}, 64'd0);
            return;
        end
        repeat (5) @(negedge clk);
        chk("rx_start_bit", {63'b0, uart_tx}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (10) @(negedge clk);
        chk("rx_stop_bit", {63'b0, uart_tx}, 64'd1);
    endtask

    task automatic rx_chars(input string exp, input string tag, input int from, input int to);
        logic [7:0] b;
        for (int k = from; k <= to; k++) begin
            rx_byte(b);
            chk($sformatf("%s_c%0d", tag, k), {56'b0, b}, {56'b0, exp[k]});
        end
    endtask

    task automatic start_word(input logic [63:0] w, input bit hold, input logic [63:0] nxt,
                              input string tag);
        resp_data  = w;
        resp_valid = 1'b1;
        chk({tag, "_ready"}, {63'b0, resp_ready}, 64'd1);
        @(negedge clk);
        chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
        chk({tag, "_load_high"}, {63'b0, uart_tx}, 64'd1);
        chk({tag, "_ready_low"}, {63'b0, resp_ready}, 64'd0);
        if (hold) begin
            resp_data = nxt;
        end else begin
            resp_valid = 1'b0;
            resp_data  = ~w;
        end
        @(negedge clk);
        chk({tag, "_start_latency"}, {63'b0, uart_tx}, 64'd0);
    endtask

    task automatic finish_line(input string tag);
        int n = 0;
        exp_frames++;
        while (busy !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, {63'b0, busy}, 64'd0);
        chk({tag, "_frames"}, {48'b0, frames_sent}, 64'(exp_frames));
    endtask

    task automatic b2b_accept(input string tag);
        int n = 0;
        exp_frames++;
        while (busy !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_gap"}, 64'(n), 64'd5);
        chk({tag, "_ready"}, {63'b0, resp_ready}, 64'd1);
        chk({tag, "_frames"}, {48'b0, frames_sent}, 64'(exp_frames));
        @(negedge clk);
        chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
        chk({tag, "_load_high"}, {63'b0, uart_tx}, 64'd1);
        resp_valid = 1'b0;
        resp_data  = 64'h0;
        @(negedge clk);
        chk({tag, "_start_latency"}, {63'b0, uart_tx}, 64'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        string l0 = "0123456789ABCDEF\r\n";
        string lf = "FFFFFFFFFFFFFFFF\r\n";
        string la = "A000000000000009\r\n";
        string lx = "DEADBEEF01234567\r\n";
        string ly = "89ABCDEF76543210\r\n";
        string lz = "0F1E2D3C4B5A6978\r\n";
        int n;

        reset_n    = 1'b0;
        resp_valid = 1'b0;
        resp_data  = 64'h0;
        repeat (5) @(negedge clk);
        chk("rst_tx", {63'b0, uart_tx}, 64'd1);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_ready", {63'b0, resp_ready}, 64'd0);
        chk("rst_frames", {48'b0, frames_sent}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'b0, resp_ready}, 64'd1);
        chk("post_rst_tx", {63'b0, uart_tx}, 64'd1);
        chk("post_rst_busy", {63'b0, busy}, 64'd0);

        start_word(64'h0123456789ABCDEF, 1'b0, 64'h0, "l0");
        rx_chars(l0, "l0", 0, 17);
        finish_line("l0");

        start_word(64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hA000000000000009, "lf");
        rx_chars(lf, "lf", 0, 17);
        b2b_accept("b2b");
        rx_chars(la, "la", 0, 17);
        finish_line("la");

        start_word(64'hDEADBEEF01234567, 1'b0, 64'h0, "lx");
        rx_chars(lx, "lx", 0, 2);
        for (int i = 0; i < 3; i++) begin
            resp_data  = 64'h89ABCDEF76543210;
            resp_valid = 1'b1;
            chk($sformatf("ign_ready_%0d", i), {63'b0, resp_ready}, 64'd0);
            chk($sformatf("ign_busy_%0d", i), {63'b0, busy}, 64'd1);
            @(negedge clk);
        end
        resp_valid = 1'b0;
        resp_data  = 64'h0;
        @(negedge clk);
        resp_data  = 64'h89ABCDEF76543210;
        resp_valid = 1'b1;
        rx_chars(lx, "lx", 3, 17);
        b2b_accept("ign");
        rx_chars(ly, "ly", 0, 17);
        finish_line("ly");

        start_word(64'h0123456789ABCDEF, 1'b0, 64'h0, "mr");
        rx_chars(l0, "mr", 0, 4);
        n = 0;
        while (uart_tx !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (25) @(negedge clk);
        chk("mr_pre_tx", {63'b0, uart_tx}, 64'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_tx", {63'b0, uart_tx}, 64'd1);
        chk("mr_busy", {63'b0, busy}, 64'd0);
        chk("mr_frames", {48'b0, frames_sent}, 64'd0);
        chk("mr_ready", {63'b0, resp_ready}, 64'd0);
        exp_frames = 0;
        @(negedge clk);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mr_post_ready", {63'b0, resp_ready}, 64'd1);
        start_word(64'h0F1E2D3C4B5A6978, 1'b0, 64'h0, "lz");
        rx_chars(lz, "lz", 0, 17);
        finish_line("lz");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
